lsf_hit_sequencer: RTL
======================

// Module: lsf_hit_sequencer
// PURPOSE
// Upstream feeder for the LSF spy-buffer/Legendre stage. It accepts one segment-finder ROI (SLC) and the
// HEG hit stream for that ROI, then replays them in order as roi/roi_we, mdt_hit/mdt_hit_we.
// It closes each window with a single-cycle eof pulse and a histogram_accumulation_count.
// It enforces per-ROI hit limits, a window timeout and one-ROI-in-flight sequencing.
// PARAMETERS
// MAX_HITS     32    max hits forwarded per ROI (1..1023); excess hits are dropped
// TIMEOUT      512   cycles in COLLECT with no accepted hit before forced close (1..65535)
// MIN_GAP      4     idle cycles after eof before a new ROI is accepted (0..15)
// PORTS
// clock           in   1               system clock
// reset           in   1               async, active-high; clears all state and outputs
// i_slc           in   HEG2SFSLC_LEN   ROI descriptor from HEG
// i_slc_vld       in   1               ROI valid, single-cycle qualifier
// i_hit           in   HEG2SFHIT_LEN   hit from HEG
// i_hit_vld       in   1               hit valid
// i_hit_last      in   1               end of ROI hit list; valid with or without i_hit_vld
// i_ds_af         in   1               downstream hit-buffer almost_full
// o_ready         out  1               1 when in IDLE and able to take i_slc_vld
// o_roi           out  HEG2SFSLC_LEN   registered ROI to LSF
// o_roi_we        out  1               ROI write strobe
// o_mdt_hit       out  HEG2SFHIT_LEN   registered hit to LSF
// o_mdt_hit_we    out  1               hit write strobe
// o_eof           out  1               end-of-frame pulse to LSF
// o_hist_acc_cnt  out  10              hits forwarded in the closed window; held until next eof
// o_drop_cnt      out  16              saturating count of dropped hits and dropped SLCs
// BEHAVIOUR
// - Reset values: every output is 0 and the FSM is in IDLE. Reset during any state aborts the window with no eof.
// - FSM states: IDLE, COLLECT, FLUSH, GAP.
// - IDLE: on i_slc_vld, latch i_slc into o_roi and pulse o_roi_we for 1 cycle (latency 1). Clear hit_cnt and the timer, then go to COLLECT.
//   o_ready=1 only in IDLE. Hits arriving in IDLE are dropped and counted.
// - COLLECT: an accepted hit is any i_hit_vld with hit_cnt<MAX_HITS and i_ds_af=0.
//   An accepted hit sets o_mdt_hit<=i_hit and o_mdt_hit_we=1 the next cycle, increments hit_cnt and resets the timer.
//   A hit that is not accepted is dropped and increments o_drop_cnt. Hits are never stalled or queued.
// - i_hit_last: processed in the same cycle as any accompanying hit (accept or drop first), then go to FLUSH.
//   The timer reaching TIMEOUT also goes to FLUSH.
// - FLUSH: o_eof=1 for exactly 1 cycle and o_hist_acc_cnt<=hit_cnt in the same cycle. Go to GAP.
//   o_eof therefore rises exactly 1 cycle after the last o_mdt_hit_we, i.e. 2 cycles after the i_hit_last input.
// - GAP: count MIN_GAP cycles, then go to IDLE. If MIN_GAP=0, go FLUSH->IDLE directly.
// - Empty ROI (i_hit_last with no hits): eof is still pulsed and o_hist_acc_cnt=0.
// - i_slc_vld outside IDLE: the SLC is dropped, o_drop_cnt increments and the current window is unaffected.
//   Same-cycle drop events increment o_drop_cnt by 1 per cycle, not per event.
// - o_drop_cnt saturates at 0xFFFF and never wraps. hit_cnt never exceeds MAX_HITS.
// - o_roi and o_mdt_hit hold their last value when the strobe is 0.
// TESTING
// 1. ROI then 5 hits on consecutive cycles, last with hit 5 -> roi_we@t+1, 5 hit_we, eof 1 cycle after 5th hit_we, acc_cnt=5.
// 2. ROI then 40 hits with MAX_HITS=32 -> exactly 32 hit_we, drop_cnt=8, acc_cnt=32.
// 3. ROI then no hits for 512 cycles -> eof at TIMEOUT expiry, acc_cnt=0; a second SLC during GAP -> drop_cnt+1, o_ready=0.
// 4. i_ds_af high for hits 3-4 of 6 -> 4 forwarded, drop_cnt=2, ordering of surviving hits preserved.
// 5. Assert reset mid-COLLECT after 3 hits -> all outputs 0 immediately, no eof; next ROI starts clean with acc_cnt counting from 0.
// 6. Back-to-back ROIs with MIN_GAP=4 -> o_ready returns 5 cycles after eof; SLC on that cycle is accepted.

Source files
------------

// File: rtl/lsf_hit_sequencer_if.sv
// Handshake bundle between the HEG-side feeder and the LSF hit sequencer.
// Signal names follow the sequencer's port list; master is the HEG/bench side.
interface lsf_hit_sequencer_if #(
   parameter int HEG2SFSLC_LEN = 48,
   parameter int HEG2SFHIT_LEN = 40
);
   logic [HEG2SFSLC_LEN-1:0] i_slc;
   logic                     i_slc_vld;
   logic [HEG2SFHIT_LEN-1:0] i_hit;
   logic                     i_hit_vld;
   logic                     i_hit_last;
   logic                     i_ds_af;
   logic                     o_ready;
   logic [HEG2SFSLC_LEN-1:0] o_roi;
   logic                     o_roi_we;
   logic [HEG2SFHIT_LEN-1:0] o_mdt_hit;
   logic                     o_mdt_hit_we;
   logic                     o_eof;
   logic [9:0]               o_hist_acc_cnt;
   logic [15:0]              o_drop_cnt;

   modport master (
      output i_slc, i_slc_vld, i_hit, i_hit_vld, i_hit_last, i_ds_af,
      input  o_ready, o_roi, o_roi_we, o_mdt_hit, o_mdt_hit_we, o_eof,
             o_hist_acc_cnt, o_drop_cnt
   );

   modport slave (
      input  i_slc, i_slc_vld, i_hit, i_hit_vld, i_hit_last, i_ds_af,
      output o_ready, o_roi, o_roi_we, o_mdt_hit, o_mdt_hit_we, o_eof,
             o_hist_acc_cnt, o_drop_cnt
   );
endinterface

// File: rtl/lsf_hit_sequencer.sv
// Replays one ROI and its HEG hit list to the LSF stage, closing each window with eof.
// Enforces per-ROI hit limit, collect timeout, and a minimum idle gap between ROIs.
module lsf_hit_sequencer #(
   parameter int MAX_HITS      = 32,
   parameter int TIMEOUT       = 512,
   parameter int MIN_GAP       = 4,
   parameter int HEG2SFSLC_LEN = 48,
   parameter int HEG2SFHIT_LEN = 40
) (
   input logic                 clock,
   input logic                 reset,
   lsf_hit_sequencer_if.slave  bus
);
   localparam logic [9:0]  MAX_HITS_C   = 10'(MAX_HITS);
   localparam logic [15:0] TIMER_LAST_C = 16'(TIMEOUT - 1);
   localparam logic [3:0]  MIN_GAP_C    = 4'(MIN_GAP);

   typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_FLUSH, ST_GAP} state_t;

   state_t                   state_r;
   state_t                   state_nxt_s;
   logic [9:0]               hit_cnt_r;
   logic [15:0]              timer_r;
   logic [3:0]               gap_cnt_r;
   logic                     hit_accept_s;
   logic                     drop_evt_s;
   logic                     slc_take_s;
   logic                     ready_r;
   logic [HEG2SFSLC_LEN-1:0] roi_r;
   logic                     roi_we_r;
   logic [HEG2SFHIT_LEN-1:0] mdt_hit_r;
   logic                     mdt_hit_we_r;
   logic                     eof_r;
   logic [9:0]               hist_acc_cnt_r;
   logic [15:0]              drop_cnt_r;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state, hit acceptance and drop detection; at most one drop counted per cycle
   always_comb begin
      state_nxt_s  = state_r;
      hit_accept_s = 1'b0;
      drop_evt_s   = 1'b0;
      slc_take_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            slc_take_s = bus.i_slc_vld;
            drop_evt_s = bus.i_hit_vld;
            if (bus.i_slc_vld) begin
               state_nxt_s = ST_COLLECT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (bus.i_hit_vld && (hit_cnt_r < MAX_HITS_C) && !bus.i_ds_af) begin
               hit_accept_s = 1'b1;
            end else begin
               hit_accept_s = 1'b0;
            end
            drop_evt_s = (bus.i_hit_vld && !hit_accept_s) || bus.i_slc_vld;
            if (bus.i_hit_last) begin
               state_nxt_s = ST_FLUSH;
            end else if (!hit_accept_s && (timer_r == TIMER_LAST_C)) begin
               state_nxt_s = ST_FLUSH;
            end else begin
               state_nxt_s = ST_COLLECT;
            end
         end
         ST_FLUSH: begin
            drop_evt_s = bus.i_hit_vld || bus.i_slc_vld;
            if (MIN_GAP == 0) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_GAP;
            end
         end
         ST_GAP: begin
            drop_evt_s = bus.i_hit_vld || bus.i_slc_vld;
            if (gap_cnt_r == MIN_GAP_C) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_GAP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Window bookkeeping: hit count, inactivity timer, post-eof gap counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit_cnt_r <= 10'd0;
         timer_r   <= 16'd0;
         gap_cnt_r <= 4'd0;
      end else begin
         if (slc_take_s) begin
            hit_cnt_r <= 10'd0;
            timer_r   <= 16'd0;
         end else if (state_r == ST_COLLECT) begin
            if (hit_accept_s) begin
               hit_cnt_r <= hit_cnt_r + 10'd1;
               timer_r   <= 16'd0;
            end else begin
               timer_r   <= timer_r + 16'd1;
            end
         end else begin
            timer_r <= timer_r;
         end
         if (state_r == ST_GAP) begin
            gap_cnt_r <= gap_cnt_r + 4'd1;
         end else begin
            gap_cnt_r <= 4'd0;
         end
      end
   end

   // Registered datapath and strobes toward LSF
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         roi_r          <= '0;
         roi_we_r       <= 1'b0;
         mdt_hit_r      <= '0;
         mdt_hit_we_r   <= 1'b0;
         eof_r          <= 1'b0;
         hist_acc_cnt_r <= 10'd0;
         ready_r        <= 1'b0;
      end else begin
         roi_we_r     <= slc_take_s;
         mdt_hit_we_r <= hit_accept_s;
         eof_r        <= (state_r == ST_FLUSH);
         ready_r      <= (state_nxt_s == ST_IDLE);
         if (slc_take_s) begin
            roi_r <= bus.i_slc;
         end else begin
            roi_r <= roi_r;
         end
         if (hit_accept_s) begin
            mdt_hit_r <= bus.i_hit;
         end else begin
            mdt_hit_r <= mdt_hit_r;
         end
         if (state_r == ST_FLUSH) begin
            hist_acc_cnt_r <= hit_cnt_r;
         end else begin
            hist_acc_cnt_r <= hist_acc_cnt_r;
         end
      end
   end

   // Saturating drop counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         drop_cnt_r <= 16'd0;
      end else if (drop_evt_s && (drop_cnt_r != 16'hFFFF)) begin
         drop_cnt_r <= drop_cnt_r + 16'd1;
      end else begin
         drop_cnt_r <= drop_cnt_r;
      end
   end

   assign bus.o_ready        = ready_r;
   assign bus.o_roi          = roi_r;
   assign bus.o_roi_we       = roi_we_r;
   assign bus.o_mdt_hit      = mdt_hit_r;
   assign bus.o_mdt_hit_we   = mdt_hit_we_r;
   assign bus.o_eof          = eof_r;
   assign bus.o_hist_acc_cnt = hist_acc_cnt_r;
   assign bus.o_drop_cnt     = drop_cnt_r;
endmodule
